imem_arbiter: RTL and testbench

Arbitrates one shared single-port memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). Sits between the fetch/memory stages and the memory interface. Allows one outstanding transaction at a time and tracks its owner. Handles fetch cancellation on taken jumps by draining and discarding the in-flight instruction response. Data requests have priority; an optional starvation guard bounds fetch latency.

---
 rtl/imem_arbiter_if.sv | 53 +++++
 rtl/imem_arbiter.sv | 143 ++++++++++++++
 tb/tb_imem_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around imem_arbiter.
// slave = arbiter view; master = the surrounding stages and the memory.
interface imem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            f_req;
   logic [AW-1:0]   f_addr;
   logic            f_kill;
   logic            f_gnt;
   logic [DW-1:0]   f_rdata;
   logic            f_rvalid;

   logic            d_req;
   logic            d_we;
   logic [AW-1:0]   d_addr;
   logic [DW-1:0]   d_wdata;
   logic [DW/8-1:0] d_be;
   logic            d_gnt;
   logic [DW-1:0]   d_rdata;
   logic            d_rvalid;

   logic            m_req;
   logic            m_we;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic [DW/8-1:0] m_be;
   logic            m_gnt;
   logic [DW-1:0]   m_rdata;
   logic            m_rvalid;

   logic            busy;

   modport slave (
      input  f_req, f_addr, f_kill,
      output f_gnt, f_rdata, f_rvalid,
      input  d_req, d_we, d_addr, d_wdata, d_be,
      output d_gnt, d_rdata, d_rvalid,
      output m_req, m_we, m_addr, m_wdata, m_be,
      input  m_gnt, m_rdata, m_rvalid,
      output busy
   );

   modport master (
      output f_req, f_addr, f_kill,
      input  f_gnt, f_rdata, f_rvalid,
      output d_req, d_we, d_addr, d_wdata, d_be,
      input  d_gnt, d_rdata, d_rvalid,
      input  m_req, m_we, m_addr, m_wdata, m_be,
      output m_gnt, m_rdata, m_rvalid,
      input  busy
   );
endinterface

// File: rtl/imem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data.
// Define IMEM_ARB_STARVE_GUARD_EN to bound fetch starvation under data priority.
module imem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   imem_arbiter_if.slave       bus,
   output logic [1:0]          dbg_state
);

   // Handshake: a requester holds req and its command stable until gnt; gnt is
   // combinational (winner gnt = m_gnt in IDLE). Accept = m_req & m_gnt. The
   // response comes back as a single-cycle m_rvalid, forwarded as f_/d_rvalid.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_F = 2'd1,
      BUSY_D = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic in_idle;
   logic f_pres;
   logic force_fetch;
   logic fetch_wins;
   logic data_wins;
   logic f_acc;
   logic d_acc;

   if (STARVE_MAX < 1) begin : g_bad_starve_max
      $error("imem_arbiter: STARVE_MAX must be at least 1");
   end

   // Requests are masked during reset so every output reads 0 while rst is high.
   assign in_idle    = (state == IDLE) && !rst;
   assign f_pres     = bus.f_req && !bus.f_kill;
   assign fetch_wins = in_idle && f_pres && (force_fetch || !bus.d_req);
   assign data_wins  = in_idle && bus.d_req && !fetch_wins;
   assign f_acc      = fetch_wins && bus.m_gnt;
   assign d_acc      = data_wins && bus.m_gnt;

`ifdef IMEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt;

   assign force_fetch = (starve_cnt == CNT_W'(STARVE_MAX));

   // Counts data wins over a waiting fetch; holds outside IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (f_acc) begin
            starve_cnt <= '0;
         end else if (d_acc && f_pres) begin
            starve_cnt <= starve_cnt + 1'b1;
         end else if (!f_pres) begin
            starve_cnt <= '0;
         end
      end
   end
`else
   assign force_fetch = 1'b0;
`endif

   always_comb begin
      bus.m_req   = 1'b0;
      bus.m_we    = 1'b0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.m_be    = '0;
      if (data_wins) begin
         bus.m_req   = 1'b1;
         bus.m_we    = bus.d_we;
         bus.m_addr  = bus.d_addr;
         bus.m_wdata = bus.d_wdata;
         bus.m_be    = bus.d_be;
      end else if (fetch_wins) begin
         bus.m_req   = 1'b1;
         bus.m_addr  = bus.f_addr;
         bus.m_be    = '1;
      end
   end

   assign bus.f_gnt = f_acc;
   assign bus.d_gnt = d_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bus.f_rvalid = 1'b0;
      bus.d_rvalid = 1'b0;
      case (state)
         IDLE: begin
            // m_rvalid here is stale (e.g. across a reset) and is ignored.
            if (f_acc) begin
               state_nxt = BUSY_F;
            end else if (d_acc) begin
               state_nxt = BUSY_D;
            end
         end
         BUSY_F: begin
            if (bus.m_rvalid) begin
               bus.f_rvalid = !bus.f_kill;
               state_nxt    = IDLE;
            end else if (bus.f_kill) begin
               state_nxt = DRAIN;
            end
         end
         BUSY_D: begin
            if (bus.m_rvalid) begin
               bus.d_rvalid = 1'b1;
               state_nxt    = IDLE;
            end
         end
         DRAIN: begin
            if (bus.m_rvalid) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.f_rdata = bus.m_rdata;
   assign bus.d_rdata = bus.m_rdata;
   assign bus.busy    = (state != IDLE);
   assign dbg_state   = state;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: grants, responses, kill/drain, stalls,
// starvation guard (when IMEM_ARB_STARVE_GUARD_EN is defined) and reset.
module tb_imem_arbiter;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY_F = 2'd1;
   localparam logic [1:0] ST_BUSY_D = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

`ifdef IMEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   imem_arbiter_if #(.AW(32), .DW(32)) bus ();

   imem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pops the expected read data for a response the bench knows is due.
   task automatic expect_resp(input string tag, input logic vld, input logic [31:0] data);
      check_eq({tag, "_rvalid"}, 32'(vld), 32'd1);
      if (exp_q.size() == 0) begin
         check_eq({tag, "_q_empty"}, 32'd1, 32'd0);
      end else begin
         check_eq({tag, "_rdata"}, data, exp_q.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      bus.f_req    = 1'b0;
      bus.f_addr   = '0;
      bus.f_kill   = 1'b0;
      bus.d_req    = 1'b0;
      bus.d_we     = 1'b0;
      bus.d_addr   = '0;
      bus.d_wdata  = '0;
      bus.d_be     = '0;
      bus.m_gnt    = 1'b0;
      bus.m_rdata  = '0;
      bus.m_rvalid = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      bus.f_req = 1'b1;
      #12;
      check_eq("rst_m_req", 32'(bus.m_req), 32'd0);
      check_eq("rst_f_gnt", 32'(bus.f_gnt), 32'd0);
      check_eq("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
      check_eq("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
      check_eq("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      tick();
      bus.f_req = 1'b0;
      rst = 1'b0;

      // Single fetch
      tick();
      bus.f_req = 1'b1; bus.f_addr = 32'h100; bus.m_gnt = 1'b1;
      exp_q.push_back(32'hDEADBEEF);
      settle();
      check_eq("t1_f_gnt", 32'(bus.f_gnt), 32'd1);
      check_eq("t1_m_addr", bus.m_addr, 32'h100);
      check_eq("t1_m_we", 32'(bus.m_we), 32'd0);
      check_eq("t1_m_be", 32'(bus.m_be), 32'hF);
      check_eq("t1_busy_c0", 32'(bus.busy), 32'd0);
      tick();
      bus.f_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEADBEEF;
      settle();
      check_eq("t1_busy_c1", 32'(bus.busy), 32'd1);
      check_eq("t1_m_req_c1", 32'(bus.m_req), 32'd0);
      expect_resp("t1_f", bus.f_rvalid, bus.f_rdata);
      tick();
      bus.m_rvalid = 1'b0;
      settle();
      check_eq("t1_busy_c2", 32'(bus.busy), 32'd0);
      check_eq("t1_f_rvalid_c2", 32'(bus.f_rvalid), 32'd0);

      // Simultaneous fetch and store: data wins
      tick();
      bus.f_req = 1'b1; bus.f_addr = 32'h104;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h55; bus.d_be = 4'hF;
      bus.m_gnt = 1'b1;
      settle();
      check_eq("t2_d_gnt", 32'(bus.d_gnt), 32'd1);
      check_eq("t2_f_gnt", 32'(bus.f_gnt), 32'd0);
      check_eq("t2_m_we", 32'(bus.m_we), 32'd1);
      check_eq("t2_m_addr", bus.m_addr, 32'h2000);
      check_eq("t2_m_wdata", bus.m_wdata, 32'h55);
      tick();
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0;
      settle();
      check_eq("t2_d_rvalid", 32'(bus.d_rvalid), 32'd1);
      check_eq("t2_no_gnt_in_resp", 32'(bus.f_gnt), 32'd0);
      tick();
      bus.m_rvalid = 1'b0;
      exp_q.push_back(32'h1234_5678);
      settle();
      check_eq("t2_f_gnt_next", 32'(bus.f_gnt), 32'd1);
      check_eq("t2_f_m_addr", bus.m_addr, 32'h104);
      tick();
      bus.f_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1234_5678;
      settle();
      expect_resp("t2_f", bus.f_rvalid, bus.f_rdata);
      check_eq("t2_d_rvalid_f", 32'(bus.d_rvalid), 32'd0);
      tick();
      clear_inputs();

      // Kill after accept, late response drained
      tick();
      bus.f_req = 1'b1; bus.f_addr = 32'h200; bus.m_gnt = 1'b1;
      settle();
      check_eq("t3_f_gnt", 32'(bus.f_gnt), 32'd1);
      tick();
      bus.f_req = 1'b0; bus.m_gnt = 1'b0; bus.f_kill = 1'b1;
      settle();
      check_eq("t3_state_busy_f", 32'(dbg_state), 32'(ST_BUSY_F));
      tick();
      bus.f_kill = 1'b0;
      settle();
      check_eq("t3_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
      check_eq("t3_busy_drain", 32'(bus.busy), 32'd1);
      tick();
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
      settle();
      check_eq("t3_drop_rvalid", 32'(bus.f_rvalid), 32'd0);
      tick();
      bus.m_rvalid = 1'b0; bus.f_req = 1'b1; bus.f_addr = 32'h300; bus.m_gnt = 1'b1;
      exp_q.push_back(32'h0000_0300);
      settle();
      check_eq("t3_state_idle", 32'(dbg_state), 32'(ST_IDLE));
      check_eq("t3_next_f_gnt", 32'(bus.f_gnt), 32'd1);
      tick();
      bus.f_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0000_0300;
      settle();
      expect_resp("t3_f", bus.f_rvalid, bus.f_rdata);
      tick();
      clear_inputs();

      // Kill in the same cycle as the response, then kill masking a request
      tick();
      bus.f_req = 1'b1; bus.f_addr = 32'h400; bus.m_gnt = 1'b1;
      tick();
      bus.f_req = 1'b0; bus.m_gnt = 1'b0; bus.f_kill = 1'b1; bus.m_rvalid = 1'b1;
      settle();
      check_eq("t3b_kill_rvalid", 32'(bus.f_rvalid), 32'd0);
      tick();
      bus.m_rvalid = 1'b0; bus.f_req = 1'b1; bus.m_gnt = 1'b1;
      settle();
      check_eq("t3b_state_idle", 32'(dbg_state), 32'(ST_IDLE));
      check_eq("t3b_killed_m_req", 32'(bus.m_req), 32'd0);
      check_eq("t3b_killed_f_gnt", 32'(bus.f_gnt), 32'd0);
      tick();
      clear_inputs();

      // Memory stalls m_gnt for 3 cycles
      tick();
      bus.f_req = 1'b1; bus.f_addr = 32'h500;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_eq("t4_stall_f_gnt", 32'(bus.f_gnt), 32'd0);
         check_eq("t4_stall_m_req", 32'(bus.m_req), 32'd1);
         check_eq("t4_stall_state", 32'(dbg_state), 32'(ST_IDLE));
         tick();
      end
      bus.m_gnt = 1'b1;
      settle();
      check_eq("t4_f_gnt", 32'(bus.f_gnt), 32'd1);
      tick();
      bus.f_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1;
      tick();
      clear_inputs();

      // Continuous fetch and load requests: guard pattern D,D,D,D,F or data only
      tick();
      bus.f_req = 1'b1; bus.f_addr = 32'h600;
      bus.d_req = 1'b1; bus.d_addr = 32'h3000; bus.d_be = 4'hF;
      bus.m_gnt = 1'b1;
      for (int k = 0; k < 10; k++) begin
         logic exp_f;
         exp_f = GUARD && ((k % 5) == 4);
         bus.m_rvalid = 1'b0;
         settle();
         check_eq($sformatf("t5_f_gnt_%0d", k), 32'(bus.f_gnt), 32'(exp_f));
         check_eq($sformatf("t5_d_gnt_%0d", k), 32'(bus.d_gnt), 32'(!exp_f));
         tick();
         bus.m_rvalid = 1'b1; bus.m_rdata = 32'hA000_0000 + 32'(k);
         exp_q.push_back(32'hA000_0000 + 32'(k));
         settle();
         if (exp_f) begin
            expect_resp($sformatf("t5_f_%0d", k), bus.f_rvalid, bus.f_rdata);
         end else begin
            expect_resp($sformatf("t5_d_%0d", k), bus.d_rvalid, bus.d_rdata);
         end
         tick();
      end
      clear_inputs();

      // Reset while a load is outstanding, stray response afterwards
      tick();
      bus.d_req = 1'b1; bus.d_addr = 32'h10; bus.m_gnt = 1'b1;
      settle();
      check_eq("t6_d_gnt", 32'(bus.d_gnt), 32'd1);
      tick();
      rst = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFE_F00D;
      settle();
      check_eq("t6_rst_busy", 32'(bus.busy), 32'd0);
      check_eq("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check_eq("t6_rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      check_eq("t6_rst_m_req", 32'(bus.m_req), 32'd0);
      check_eq("t6_rst_d_gnt", 32'(bus.d_gnt), 32'd0);
      tick();
      rst = 1'b0; bus.d_req = 1'b0; bus.m_gnt = 1'b0;
      settle();
      check_eq("t6_stray_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      check_eq("t6_stray_f_rvalid", 32'(bus.f_rvalid), 32'd0);
      check_eq("t6_stray_busy", 32'(bus.busy), 32'd0);
      tick();
      clear_inputs();
      settle();
      check_eq("t6_final_state", 32'(dbg_state), 32'(ST_IDLE));
      check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
